// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  // port 0: multicycle CPU
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] rdata0;
  logic          ready0;

  // port 1: loader / debug master
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] rdata1;
  logic          ready1;

  // memory side and status
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    grant;
  logic          busy;

  // arbiter view
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output rdata0, ready0, rdata1, ready1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output grant, busy
  );

  // requesters + memory view
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  rdata0, ready0, rdata1, ready1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  grant, busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port fixed-latency memory.
// Every output is registered; requests are only looked at while IDLE.
module mem_arbiter #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned WAIT = 1   // read latency, 0..15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned   CW       = 4;
  localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;    // port granted most recently
  logic          owner;   // port owning the current access
  logic          wr;      // current access is a write

  logic          any_req_c;
  logic          sel_c;
  logic          we_sel_c;
  logic [AW-1:0] addr_sel_c;
  logic [DW-1:0] wdata_sel_c;

  // Round-robin pick among raw requests; consumed only in IDLE.
  always_comb begin
    any_req_c   = bus.req0 | bus.req1;
    sel_c       = 1'b0;
    if (bus.req0 && bus.req1) begin
      sel_c = ~last;
    end else if (bus.req1) begin
      sel_c = 1'b1;
    end
    we_sel_c    = sel_c ? bus.we1    : bus.we0;
    addr_sel_c  = sel_c ? bus.addr1  : bus.addr0;
    wdata_sel_c = sel_c ? bus.wdata1 : bus.wdata0;
  end

  // Access sequencer: IDLE grants, ACCESS waits out memory latency, RESP pulses ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= 1'b1;
      owner         <= 1'b0;
      wr            <= 1'b0;
      bus.grant     <= 2'b00;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.ready0    <= 1'b0;
      bus.ready1    <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req_c) begin
            bus.mem_addr  <= addr_sel_c;
            bus.mem_wdata <= wdata_sel_c;
            bus.mem_we    <= we_sel_c;
            bus.mem_en    <= 1'b1;
            bus.grant     <= sel_c ? 2'b10 : 2'b01;
            bus.busy      <= 1'b1;
            last          <= sel_c;
            owner         <= sel_c;
            wr            <= we_sel_c;
            cnt           <= '0;
            state         <= ACCESS;
          end
        end

        ACCESS: begin
          // write strobe lives only in the first access cycle
          bus.mem_we <= 1'b0;
          if (cnt == WAIT_CNT) begin
            if (!wr) begin
              if (owner) begin
                bus.rdata1 <= bus.mem_rdata;
              end else begin
                bus.rdata0 <= bus.mem_rdata;
              end
            end
            bus.mem_en <= 1'b0;
            bus.ready0 <= ~owner;
            bus.ready1 <= owner;
            state      <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RESP: begin
          bus.ready0 <= 1'b0;
          bus.ready1 <= 1'b0;
          bus.grant  <= 2'b00;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: WAIT=1 instance against a transaction
// model every cycle, plus a WAIT=0 instance with directed literal checks.
module tb_mem_arbiter;

  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst1, rst0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) b0 ();

  mem_arbiter #(.AW(32), .DW(32), .WAIT(1)) dut1 (.clk(clk), .reset(rst1), .bus(b1));
  mem_arbiter #(.AW(32), .DW(32), .WAIT(0)) dut0 (.clk(clk), .reset(rst0), .bus(b0));

  int errors = 0;
  int checks = 0;

  // memory content as a pure function of the address
  function automatic logic [31:0] mval(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C020044;
    if (a == 32'h0)  return 32'h20080005;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // memory: data valid only WAIT cycles after mem_en rises, garbage otherwise
  int en1 = 0;
  int en0 = 0;
  always @(posedge clk) begin
    en1 <= b1.mem_en ? en1 + 1 : 0;
    en0 <= b0.mem_en ? en0 + 1 : 0;
  end
  assign b1.mem_rdata = (b1.mem_en && en1 == 1) ? mval(b1.mem_addr) : ~mval(b1.mem_addr);
  assign b0.mem_rdata = (b0.mem_en && en0 == 0) ? mval(b0.mem_addr) : ~mval(b0.mem_addr);

  // transaction model of the WAIT=1 instance: age counts cycles since the grant edge
  bit          m_act, m_port, m_we, m_last;
  int          m_age;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [2];
  bit          pend [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_ready(input int p);
    return m_act && m_age == W1 + 2 && int'(m_port) == p;
  endfunction

  task automatic model_step();
    if (rst1) begin
      m_act = 0; m_age = 0; m_we = 0; m_port = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (!m_act) begin
      if (b1.req0 || b1.req1) begin
        m_port  = (b1.req0 && b1.req1) ? !m_last : b1.req1;
        m_last  = m_port;
        m_act   = 1;
        m_age   = 1;
        m_we    = m_port ? b1.we1    : b1.we0;
        m_addr  = m_port ? b1.addr1  : b1.addr0;
        m_wdata = m_port ? b1.wdata1 : b1.wdata0;
      end
    end else begin
      if (m_age == W1 + 1 && !m_we) m_rdata[m_port] = mval(m_addr);
      if (m_age == W1 + 2) m_act = 0;
      else m_age++;
    end
  endtask

  // compare every output of the WAIT=1 instance against the model
  task automatic compare();
    bit acc;
    acc = m_act && m_age <= W1 + 1;
    chk("mem_en",    64'(b1.mem_en),    64'(acc));
    chk("mem_we",    64'(b1.mem_we),    64'(m_act && m_age == 1 && m_we));
    chk("mem_addr",  64'(b1.mem_addr),  64'(m_addr));
    chk("mem_wdata", 64'(b1.mem_wdata), 64'(m_wdata));
    chk("grant",     64'(b1.grant),     m_act ? (m_port ? 64'd2 : 64'd1) : 64'd0);
    chk("busy",      64'(b1.busy),      64'(m_act));
    chk("ready0",    64'(b1.ready0),    64'(m_ready(0)));
    chk("ready1",    64'(b1.ready1),    64'(m_ready(1)));
    chk("rdata0",    64'(b1.rdata0),    64'(m_rdata[0]));
    chk("rdata1",    64'(b1.rdata1),    64'(m_rdata[1]));
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      b1.req0 = r; b1.we0 = w; b1.addr0 = a; b1.wdata0 = d;
    end else begin
      b1.req1 = r; b1.we1 = w; b1.addr1 = a; b1.wdata1 = d;
    end
  endtask

  task automatic drop_done();
    for (int p = 0; p < 2; p++)
      if (m_ready(p)) set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic stim_random();
    for (int p = 0; p < 2; p++) begin
      if (m_ready(p)) pend[p] = 0;
      if (!pend[p]) begin
        if ($urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFC, $urandom);
        end else begin
          set_port(p, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end else if (m_act && int'(m_port) == p && $urandom_range(0, 3) == 0) begin
        // latched access must ignore changes after the grant
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFC, $urandom);
      end
    end
    rst1 = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    rst1 = 1'b1; rst0 = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    b0.req0 = 0; b0.we0 = 0; b0.addr0 = '0; b0.wdata0 = '0;
    b0.req1 = 0; b0.we1 = 0; b0.addr1 = '0; b0.wdata1 = '0;
    m_act = 0; m_age = 0; m_last = 1; m_port = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    pend[0] = 0; pend[1] = 0;
    @(negedge clk);
    cycle();
    cycle();
    rst1 = 1'b0; rst0 = 1'b0;

    // reset state, literal
    chk("rst_grant",  64'(b1.grant),    64'd0);
    chk("rst_mem_en", 64'(b1.mem_en),   64'd0);
    chk("rst_addr",   64'(b1.mem_addr), 64'd0);
    chk("rst_rdata0", 64'(b1.rdata0),   64'd0);
    chk("rst_w0_grant", 64'(b0.grant),  64'd0);

    // CPU read of 0x40, address wiggled during the access
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    cycle();
    chk("rd_en1",    64'(b1.mem_en),   64'd1);
    chk("rd_addr1",  64'(b1.mem_addr), 64'h40);
    chk("rd_grant",  64'(b1.grant),    64'd1);
    set_port(0, 1'b1, 1'b0, 32'h80, 32'h0);
    cycle();
    chk("rd_en2",    64'(b1.mem_en),   64'd1);
    chk("rd_addr2",  64'(b1.mem_addr), 64'h40);
    cycle();
    chk("rd_ready0", 64'(b1.ready0),   64'd1);
    chk("rd_rdata0", 64'(b1.rdata0),   64'h8C020044);
    chk("rd_en_off", 64'(b1.mem_en),   64'd0);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("rd_pulse",  64'(b1.ready0),   64'd0);
    chk("rd_hold",   64'(b1.rdata0),   64'h8C020044);

    // loader write
    set_port(1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    cycle();
    chk("wr_we",     64'(b1.mem_we),    64'd1);
    chk("wr_addr",   64'(b1.mem_addr),  64'h100);
    chk("wr_wdata",  64'(b1.mem_wdata), 64'hDEADBEEF);
    chk("wr_grant",  64'(b1.grant),     64'd2);
    cycle();
    chk("wr_we_off", 64'(b1.mem_we),    64'd0);
    cycle();
    chk("wr_ready1", 64'(b1.ready1),    64'd1);
    chk("wr_rdata1", 64'(b1.rdata1),    64'd0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // contention after reset: grants alternate starting with the CPU
    rst1 = 1'b1;
    cycle();
    rst1 = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (i % 4 == 0) chk("rr_grant", 64'(b1.grant), ((i / 4) % 2 == 1) ? 64'd2 : 64'd1);
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // reset in the first access cycle of a port-1 read
    set_port(1, 1'b1, 1'b0, 32'h200, 32'h0);
    cycle();
    rst1 = 1'b1;
    cycle();
    rst1 = 1'b0;
    chk("mr_en",     64'(b1.mem_en), 64'd0);
    chk("mr_grant",  64'(b1.grant),  64'd0);
    chk("mr_busy",   64'(b1.busy),   64'd0);
    chk("mr_ready1", 64'(b1.ready1), 64'd0);
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    cycle();
    chk("mr_first",  64'(b1.grant),  64'd1);
    repeat (10) begin
      drop_done();
      cycle();
    end

    // WAIT=0 instance
    b0.req0 = 1; b0.we0 = 0; b0.addr0 = 32'h0;
    cycle();
    chk("w0_en",     64'(b0.mem_en),  64'd1);
    chk("w0_busy",   64'(b0.busy),    64'd1);
    cycle();
    chk("w0_ready0", 64'(b0.ready0),  64'd1);
    chk("w0_rdata0", 64'(b0.rdata0),  64'h20080005);
    chk("w0_en_off", 64'(b0.mem_en),  64'd0);
    b0.req0 = 0;
    cycle();
    chk("w0_pulse",  64'(b0.ready0),  64'd0);
    chk("w0_grant0", 64'(b0.grant),   64'd0);
    b0.req1 = 1; b0.we1 = 1; b0.addr1 = 32'h8; b0.wdata1 = 32'h1234;
    cycle();
    chk("w0_we",     64'(b0.mem_we),  64'd1);
    chk("w0_grant1", 64'(b0.grant),   64'd2);
    cycle();
    chk("w0_ready1", 64'(b0.ready1),  64'd1);
    chk("w0_we_off", 64'(b0.mem_we),  64'd0);
    chk("w0_rdata1", 64'(b0.rdata1),  64'd0);
    b0.req1 = 0;
    cycle();

    // randomized traffic with occasional resets
    pend[0] = 0; pend[1] = 0;
    repeat (3000) begin
      stim_random();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory between two requesters: the multicycle CPU (port 0) and the loader/debug master (port 1).
- Sits between the CPU top level and the memory. It serializes accesses and returns per-port ready pulses.
- The CPU stalls its state machine until its ready pulse arrives.
- Memory is modelled as fixed-latency, with a WAIT-cycle read delay.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- WAIT, 1, memory read latency in cycles; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  CPU request; held high until ready0.
- we0  in  1  CPU write enable; qualified by req0.
- addr0  in  AW  CPU byte address.
- wdata0  in  DW  CPU write data.
- rdata0  out  DW  CPU read data; valid while ready0=1.
- ready0  out  1  CPU completion pulse, one cycle.
- req1, we1, addr1, wdata1, rdata1, ready1: same as port 0, for the loader/debug master.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid WAIT cycles after mem_en rises.
- grant  out  2  one-hot owner of the current access; 00 when idle.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- All outputs are registered or decoded from state. There is no combinational path from req*/addr* to mem_*.
- Reset (synchronous, active-high; overrides everything, including mid-access):
  - state=IDLE, cnt=0.
  - grant=00, busy=0, mem_en=0, mem_we=0.
  - mem_addr=0, mem_wdata=0.
  - ready0=ready1=0, rdata0=rdata1=0.
  - last=1, so the CPU wins the first tie.
  - An in-flight access is abandoned. No ready pulse is issued for it; the requester must re-issue.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only reqN high: grant port N.
  - Both high: grant the port != last (round-robin).
  - On grant, at the next edge:
    - latch addrN/weN/wdataN into mem_addr/mem_we/mem_wdata;
    - mem_en=1, grant=onehot(N), last=N, cnt=0;
    - go to ACCESS.
- ACCESS:
  - mem_en=1 throughout.
  - mem_we=1 only in the first ACCESS cycle (cnt==0), cleared at the following edge.
  - mem_addr/mem_wdata are held stable.
  - cnt increments each cycle.
  - When cnt==WAIT, at the edge:
    - if a read, capture mem_rdata into rdataN, otherwise hold rdataN;
    - mem_en=0;
    - go to RESP.
  - WAIT=0 gives exactly one ACCESS cycle.
- RESP:
  - readyN=1 for exactly one cycle; the other ready stays 0.
  - grant is held, busy=1.
  - Next edge: readyN=0, grant=00, go to IDLE.
- Latency: the request is sampled at edge E. readyN is high during cycle E+WAIT+2, i.e. WAIT+3 cycles per access including the IDLE sampling cycle.
- Requester rules:
  - reqN, addrN, weN and wdataN are stable from assertion until the readyN cycle.
  - A requester may keep reqN high after ready to issue back-to-back accesses. That request is re-sampled in the following IDLE cycle, with round-robin applied.
- Changes to reqN/addrN during ACCESS or RESP are ignored; the latched values are used.
- rdataN holds its value after ready until the next read completes on that port.
- cnt width is 4 bits. cnt never exceeds WAIT.

Test Plan:
- Reset then single CPU read (WAIT=1): req0=1, we0=0, addr0=0x40, mem returns 0x8C020044. Required: mem_en high 2 cycles with mem_addr=0x40; ready0 high exactly in the 4th cycle after req0 sampled; rdata0=0x8C020044; ready1 stays 0.
- Loader write: req1=1, we1=1, addr1=0x100, wdata1=0xDEADBEEF. Required: mem_we=1 for exactly one cycle with mem_addr=0x100 and mem_wdata=0xDEADBEEF; grant=10; ready1 one-cycle pulse; rdata1 unchanged.
- Contention: req0 and req1 both held high for 4 accesses after reset. Required: grants alternate 01,10,01,10; no cycle has both readies high.
- WAIT=0 instance: CPU read of 0x0 returning 0x20080005. Required: one ACCESS cycle; ready0 in cycle E+2; rdata0=0x20080005.
- Reset mid-ACCESS: assert reset during the cycle cnt==0 of a port-1 read. Required next cycle: state IDLE, mem_en=0, grant=00, no ready pulse. A following simultaneous request grants port 0 first (last reset to 1).
- Input instability: change addr0 from 0x40 to 0x80 during ACCESS. Required: mem_addr stays 0x40 through the access.
